// File: rtl/vec_exe_unit_if.sv
// Command, register-file read and write-back bundle for vec_exe_unit.
// The unit itself uses the slave modport; the surrounding pipeline uses master.
interface vec_exe_unit_if #(
    parameter int DATA_W   = 32,
    parameter int LANES    = 8,
    parameter int VLEN_MAX = 32,
    parameter int ADDR_W   = 5
);
    localparam int BEAT_W = (VLEN_MAX / LANES > 1) ? $clog2(VLEN_MAX / LANES) : 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              in_op;
    logic                    in_scalar;
    logic [DATA_W-1:0]       in_rs2;
    logic [DATA_W-1:0]       in_vlen;
    logic [ADDR_W-1:0]       in_rd_base;

    logic [BEAT_W-1:0]       rf_beat;
    logic [LANES*DATA_W-1:0] vs1_data;
    logic [LANES*DATA_W-1:0] vs2_data;

    logic                    wb_valid;
    logic                    wb_ready;
    logic [LANES*DATA_W-1:0] wb_data;
    logic [LANES-1:0]        wb_mask;
    logic [ADDR_W-1:0]       wb_addr;
    logic                    wb_last;

    logic                    done;
    logic                    ovf;
    logic                    zero;

    modport master (
        output in_valid, in_op, in_scalar, in_rs2, in_vlen, in_rd_base,
        output vs1_data, vs2_data, wb_ready,
        input  in_ready, rf_beat, wb_valid, wb_data, wb_mask, wb_addr, wb_last,
        input  done, ovf, zero
    );

    modport slave (
        input  in_valid, in_op, in_scalar, in_rs2, in_vlen, in_rd_base,
        input  vs1_data, vs2_data, wb_ready,
        output in_ready, rf_beat, wb_valid, wb_data, wb_mask, wb_addr, wb_last,
        output done, ovf, zero
    );
endinterface

// File: rtl/vec_exe_unit.sv
// Vector execute unit: walks vlen in LANES-wide beats and streams registered results to write-back.
// Optional macro VEXE_SAT_EN: ADD/SUB saturate on signed overflow instead of wrapping.
module vec_exe_unit #(
    parameter int DATA_W   = 32,
    parameter int LANES    = 8,
    parameter int VLEN_MAX = 32,
    parameter int ADDR_W   = 5
) (
    input  logic          clk,
    input  logic          rst,
    vec_exe_unit_if.slave bus
);
    localparam int BEATS  = VLEN_MAX / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(VLEN_MAX + LANES);
    localparam int SH_W   = $clog2(DATA_W);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;

`ifdef VEXE_SAT_EN
    localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    logic [0:0]              state;
    logic [BEAT_W-1:0]       beat;
    logic [BEAT_W-1:0]       last_beat;
    logic [2:0]              op;
    logic                    scalar;
    logic [DATA_W-1:0]       rs2;
    logic [ADDR_W-1:0]       rd_base;
    logic [CNT_W-1:0]        vlen_eff;
    logic                    acc_ovf;
    logic                    acc_zero;

    logic                    wb_valid_q;
    logic [LANES*DATA_W-1:0] wb_data_q;
    logic [LANES-1:0]        wb_mask_q;
    logic [ADDR_W-1:0]       wb_addr_q;
    logic                    wb_last_q;
    logic                    done_q;
    logic                    ovf_q;
    logic                    zero_q;

    logic                    in_ready;
    logic                    accept;
    logic                    issue;
    logic [CNT_W-1:0]        vlen_in;
    logic [CNT_W-1:0]        beats_in;
    logic [LANES*DATA_W-1:0] beat_data;
    logic [LANES-1:0]        beat_mask;
    logic [LANES-1:0]        beat_ovf;

    // No overlap between commands: a new one waits until the output register drains.
    assign in_ready = !rst && (state == IDLE) && !wb_valid_q;
    assign accept   = bus.in_valid && in_ready;
    assign issue    = (state == RUN) && (!wb_valid_q || bus.wb_ready);

    assign vlen_in  = (bus.in_vlen > DATA_W'(VLEN_MAX)) ? CNT_W'(VLEN_MAX) : bus.in_vlen[CNT_W-1:0];
    assign beats_in = (vlen_in + CNT_W'(LANES - 1)) / CNT_W'(LANES);

    // NOTE: every variable gets a default before the loop so no path infers a latch.
    always_comb begin
        logic [DATA_W-1:0] a, b, res, sum, diff;
        logic              ov, act;
        logic [CNT_W-1:0]  idx;
        beat_data = '0;
        beat_mask = '0;
        beat_ovf  = '0;
        a = '0; b = '0; res = '0; sum = '0; diff = '0;
        ov = 1'b0; act = 1'b0; idx = '0;
        for (int i = 0; i < LANES; i++) begin
            a    = bus.vs1_data[i*DATA_W +: DATA_W];
            b    = scalar ? rs2 : bus.vs2_data[i*DATA_W +: DATA_W];
            sum  = a + b;
            diff = a - b;
            ov   = 1'b0;
            case (op)
                OP_ADD: begin
                    res = sum;
                    ov  = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
                end
                OP_SUB: begin
                    res = diff;
                    ov  = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
                end
                OP_AND:  res = a & b;
                OP_OR:   res = a | b;
                OP_XOR:  res = a ^ b;
                OP_SLT:  res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
                OP_SLL:  res = a << b[SH_W-1:0];
                default: res = $signed(a) >>> b[SH_W-1:0];
            endcase
`ifdef VEXE_SAT_EN
            // Overflow direction always follows the sign of operand A for both ADD and SUB.
            if (ov) res = a[DATA_W-1] ? SMIN : SMAX;
`endif
            idx          = CNT_W'(beat) * CNT_W'(LANES) + CNT_W'(i);
            act          = idx < vlen_eff;
            beat_mask[i] = act;
            beat_ovf[i]  = act && ov;
            if (act) beat_data[i*DATA_W +: DATA_W] = res;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat       <= '0;
            last_beat  <= '0;
            op         <= '0;
            scalar     <= 1'b0;
            rs2        <= '0;
            rd_base    <= '0;
            vlen_eff   <= '0;
            acc_ovf    <= 1'b0;
            acc_zero   <= 1'b1;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_mask_q  <= '0;
            wb_addr_q  <= '0;
            wb_last_q  <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            done_q <= 1'b0;
            if (wb_valid_q && bus.wb_ready) begin
                wb_valid_q <= 1'b0;
                if (wb_last_q) begin
                    done_q <= 1'b1;
                    ovf_q  <= acc_ovf;
                    zero_q <= acc_zero;
                end
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        op       <= bus.in_op;
                        scalar   <= bus.in_scalar;
                        rs2      <= bus.in_rs2;
                        rd_base  <= bus.in_rd_base;
                        vlen_eff <= vlen_in;
                        acc_ovf  <= 1'b0;
                        acc_zero <= 1'b1;
                        beat     <= '0;
                        if (beats_in == '0) begin
                            done_q <= 1'b1;
                            ovf_q  <= 1'b0;
                            zero_q <= 1'b1;
                        end else begin
                            last_beat <= BEAT_W'(beats_in - CNT_W'(1));
                            state     <= RUN;
                        end
                    end
                end
                default: begin
                    if (issue) begin
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= beat_data;
                        wb_mask_q  <= beat_mask;
                        wb_addr_q  <= rd_base + ADDR_W'(beat);
                        wb_last_q  <= (beat == last_beat);
                        acc_ovf    <= acc_ovf || (|beat_ovf);
                        acc_zero   <= acc_zero && (beat_data == '0);
                        if (beat == last_beat) begin
                            beat  <= '0;
                            state <= IDLE;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.rf_beat  = beat;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_mask  = wb_mask_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.wb_last  = wb_last_q;
    assign bus.done     = done_q;
    assign bus.ovf      = ovf_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_vec_exe_unit.sv
// Scoreboard bench for vec_exe_unit: stimulus pushes expected beats/flags, a monitor pops on handshake.
// Build with +define+VEXE_SAT_EN to expect saturating ADD/SUB.
module tb_vec_exe_unit;
    localparam int DATA_W   = 32;
    localparam int LANES    = 8;
    localparam int VLEN_MAX = 32;
    localparam int ADDR_W   = 5;
    localparam int BEATS    = VLEN_MAX / LANES;
    localparam int BW       = LANES * DATA_W;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRA = 3'd7;

    typedef logic [BW-1:0] wide_t;
    typedef struct {
        wide_t             data;
        logic [LANES-1:0]  mask;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } beat_t;
    typedef struct {
        logic ovf;
        logic zero;
    } flags_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vec_exe_unit_if #(.DATA_W(DATA_W), .LANES(LANES), .VLEN_MAX(VLEN_MAX), .ADDR_W(ADDR_W)) bus ();

    vec_exe_unit #(.DATA_W(DATA_W), .LANES(LANES), .VLEN_MAX(VLEN_MAX), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wide_t vs1_mem [BEATS];
    wide_t vs2_mem [BEATS];
    assign bus.vs1_data = vs1_mem[bus.rf_beat];
    assign bus.vs2_data = vs2_mem[bus.rf_beat];

    int     n_checks = 0;
    int     n_fail   = 0;
    beat_t  exp_q [$];
    flags_t done_q [$];

    task automatic check(input string name, input wide_t act, input wide_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input wide_t d, input logic [LANES-1:0] m, input logic [ADDR_W-1:0] a, input logic l);
        beat_t e;
        e.data = d;
        e.mask = m;
        e.addr = a;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input logic o, input logic z);
        flags_t f;
        f.ovf  = o;
        f.zero = z;
        done_q.push_back(f);
    endtask

    // Monitor: compares every accepted beat and every done pulse against the queues.
    always @(negedge clk) begin : monitor
        beat_t  e;
        flags_t f;
        if (!rst) begin
            if (bus.wb_valid && bus.wb_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got beat at addr %0d, expected none", bus.wb_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_data", bus.wb_data, e.data);
                    check("wb_mask", BW'(bus.wb_mask), BW'(e.mask));
                    check("wb_addr", BW'(bus.wb_addr), BW'(e.addr));
                    check("wb_last", BW'(bus.wb_last), BW'(e.last));
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected 0");
                end else begin
                    f = done_q.pop_front();
                    check("ovf", BW'(bus.ovf), BW'(f.ovf));
                    check("zero", BW'(bus.zero), BW'(f.zero));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge (cycle 1).
    task automatic send(input logic [2:0] op, input logic sc, input logic [31:0] r2,
                        input logic [31:0] vl, input logic [ADDR_W-1:0] rd);
        int t;
        bus.in_valid   = 1'b1;
        bus.in_op      = op;
        bus.in_scalar  = sc;
        bus.in_rs2     = r2;
        bus.in_vlen    = vl;
        bus.in_rd_base = rd;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            tick();
            t++;
        end
        check("in_ready_wait", BW'(bus.in_ready), BW'(1'b1));
        tick();
        bus.in_valid = 1'b0;
    endtask

    // first_cyc is the cycle index (accept = 0) of the next falling edge.
    task automatic wait_done(input string name, input int first_cyc, input int exp_cyc);
        int cyc;
        cyc = first_cyc;
        @(negedge clk);
        while (!bus.done && cyc < first_cyc + 100) begin
            @(negedge clk);
            cyc++;
        end
        check(name, BW'(cyc), BW'(exp_cyc));
        tick();
    endtask

    task automatic load_index();
        for (int b = 0; b < BEATS; b++) begin
            for (int i = 0; i < LANES; i++) begin
                vs1_mem[b][i*DATA_W +: DATA_W] = DATA_W'(b * LANES + i);
                vs2_mem[b][i*DATA_W +: DATA_W] = '0;
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin : stimulus
        wide_t       d;
        logic [2:0]  ops  [6];
        logic [31:0] vals [6];

        bus.in_valid   = 1'b0;
        bus.in_op      = '0;
        bus.in_scalar  = 1'b0;
        bus.in_rs2     = '0;
        bus.in_vlen    = '0;
        bus.in_rd_base = '0;
        bus.wb_ready   = 1'b1;
        for (int b = 0; b < BEATS; b++) begin
            vs1_mem[b] = '0;
            vs2_mem[b] = '0;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_ready_in_reset", BW'(bus.in_ready), BW'(1'b0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", BW'(bus.in_ready), BW'(1'b1));
        check("rst_wb_valid", BW'(bus.wb_valid), BW'(1'b0));
        check("rst_wb_data", bus.wb_data, '0);
        check("rst_wb_mask", BW'(bus.wb_mask), BW'(8'h00));
        check("rst_wb_addr", BW'(bus.wb_addr), BW'(5'd0));
        check("rst_wb_last", BW'(bus.wb_last), BW'(1'b0));
        check("rst_done", BW'(bus.done), BW'(1'b0));
        check("rst_ovf", BW'(bus.ovf), BW'(1'b0));
        check("rst_zero", BW'(bus.zero), BW'(1'b1));
        check("rst_rf_beat", BW'(bus.rf_beat), BW'(2'd0));
        tick();

        // ADD, one full beat: lanes i + 10.
        for (int i = 0; i < LANES; i++) begin
            vs1_mem[0][i*DATA_W +: DATA_W] = DATA_W'(i);
            vs2_mem[0][i*DATA_W +: DATA_W] = DATA_W'(10);
            d[i*DATA_W +: DATA_W]          = DATA_W'(10 + i);
        end
        push_beat(d, 8'hFF, 5'd4, 1'b1);
        push_done(1'b0, 1'b0);
        send(OP_ADD, 1'b0, 32'd0, 32'd8, 5'd4);
        wait_done("done_cycle_add8", 1, 3);

        // SUB scalar over 11 elements, destination wraps 31 -> 0; inactive lanes hold nonzero data.
        for (int i = 0; i < LANES; i++) begin
            vs1_mem[0][i*DATA_W +: DATA_W] = DATA_W'(1);
            vs1_mem[1][i*DATA_W +: DATA_W] = (i < 3) ? DATA_W'(1) : DATA_W'(5);
            vs2_mem[0][i*DATA_W +: DATA_W] = DATA_W'(32'h55);
            vs2_mem[1][i*DATA_W +: DATA_W] = DATA_W'(32'h55);
        end
        push_beat('0, 8'hFF, 5'd31, 1'b0);
        push_beat('0, 8'h07, 5'd0, 1'b1);
        push_done(1'b0, 1'b1);
        send(OP_SUB, 1'b1, 32'd1, 32'd11, 5'd31);
        wait_done("done_cycle_sub11", 1, 4);

        // Signed overflow in lane 3.
        for (int i = 0; i < LANES; i++) begin
            vs1_mem[0][i*DATA_W +: DATA_W] = DATA_W'(i);
            vs2_mem[0][i*DATA_W +: DATA_W] = '0;
            d[i*DATA_W +: DATA_W]          = DATA_W'(i);
        end
        vs1_mem[0][3*DATA_W +: DATA_W] = 32'h7FFF_FFFF;
        vs2_mem[0][3*DATA_W +: DATA_W] = 32'h0000_0001;
`ifdef VEXE_SAT_EN
        d[3*DATA_W +: DATA_W] = 32'h7FFF_FFFF;
`else
        d[3*DATA_W +: DATA_W] = 32'h8000_0000;
`endif
        push_beat(d, 8'hFF, 5'd2, 1'b1);
        push_done(1'b1, 1'b0);
        send(OP_ADD, 1'b0, 32'd0, 32'd8, 5'd2);
        wait_done("done_cycle_ovf", 1, 3);

        // Same operands with vlen=3: the overflowing lane is masked off.
        d = '0;
        for (int i = 0; i < 3; i++) d[i*DATA_W +: DATA_W] = DATA_W'(i);
        push_beat(d, 8'h07, 5'd2, 1'b1);
        push_done(1'b0, 1'b0);
        send(OP_ADD, 1'b0, 32'd0, 32'd3, 5'd2);
        wait_done("done_cycle_vlen3", 1, 3);

        // vlen=0: no beat, done one cycle after accept.
        push_done(1'b0, 1'b1);
        send(OP_ADD, 1'b0, 32'd0, 32'd0, 5'd0);
        wait_done("done_cycle_vlen0", 1, 1);

        // Remaining ops on uniform operands A=F0F01234, B=0FF00004.
        for (int i = 0; i < LANES; i++) begin
            vs1_mem[0][i*DATA_W +: DATA_W] = 32'hF0F0_1234;
            vs2_mem[0][i*DATA_W +: DATA_W] = 32'h0FF0_0004;
        end
        ops  = '{OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLL};
        vals = '{32'hE100_1230, 32'h00F0_0004, 32'hFFF0_1234, 32'hFF00_1230, 32'h0000_0001, 32'h0F01_2340};
        for (int k = 0; k < 6; k++) begin
            push_beat({LANES{vals[k]}}, 8'hFF, 5'd7, 1'b1);
            push_done(1'b0, 1'b0);
            send(ops[k], 1'b0, 32'd0, 32'd8, 5'd7);
            wait_done("done_cycle_op", 1, 3);
        end

        // vlen=100 clamps to 32: four beats.
        load_index();
        for (int b = 0; b < BEATS; b++) begin
            for (int i = 0; i < LANES; i++) d[i*DATA_W +: DATA_W] = DATA_W'(b * LANES + i);
            push_beat(d, 8'hFF, ADDR_W'(10 + b), (b == BEATS - 1));
        end
        push_done(1'b0, 1'b0);
        send(OP_ADD, 1'b0, 32'd0, 32'd100, 5'd10);
        wait_done("done_cycle_vlen100", 1, 6);

        // SRA by per-beat shift b+1 (upper bits of B set); stall beat 1 for three cycles.
        for (int b = 0; b < BEATS; b++) begin
            for (int i = 0; i < LANES; i++) begin
                vs1_mem[b][i*DATA_W +: DATA_W] = 32'h8000_0010;
                vs2_mem[b][i*DATA_W +: DATA_W] = 32'hFFFF_FFE0 | DATA_W'(b + 1);
            end
        end
        push_beat({LANES{32'hC000_0008}}, 8'hFF, 5'd20, 1'b0);
        push_beat({LANES{32'hE000_0004}}, 8'hFF, 5'd21, 1'b0);
        push_beat({LANES{32'hF000_0002}}, 8'hFF, 5'd22, 1'b0);
        push_beat({LANES{32'hF800_0001}}, 8'hFF, 5'd23, 1'b1);
        push_done(1'b0, 1'b0);
        send(OP_SRA, 1'b0, 32'd0, 32'd32, 5'd20);
        tick();
        tick();
        bus.wb_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_wb_valid", BW'(bus.wb_valid), BW'(1'b1));
            check("stall_wb_data", bus.wb_data, {LANES{32'hE000_0004}});
            check("stall_wb_addr", BW'(bus.wb_addr), BW'(5'd21));
            check("stall_wb_last", BW'(bus.wb_last), BW'(1'b0));
            check("stall_rf_beat", BW'(bus.rf_beat), BW'(2'd2));
            check("stall_in_ready", BW'(bus.in_ready), BW'(1'b0));
            tick();
        end
        bus.wb_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("drain_wb_last", BW'(bus.wb_last), BW'(1'b1));
        check("drain_in_ready", BW'(bus.in_ready), BW'(1'b0));
        wait_done("done_cycle_stall", 9, 9);

        // Reset while beat 2 is presented: beat dropped, no done, flags back to reset values.
        load_index();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < LANES; i++) d[i*DATA_W +: DATA_W] = DATA_W'(b * LANES + i);
            push_beat(d, 8'hFF, ADDR_W'(b), 1'b0);
        end
        send(OP_ADD, 1'b0, 32'd0, 32'd32, 5'd0);
        tick();
        tick();
        tick();
        bus.wb_ready = 1'b0;
        rst          = 1'b1;
        tick();
        rst          = 1'b0;
        bus.wb_ready = 1'b1;
        @(negedge clk);
        check("midrst_wb_valid", BW'(bus.wb_valid), BW'(1'b0));
        check("midrst_in_ready", BW'(bus.in_ready), BW'(1'b1));
        check("midrst_rf_beat", BW'(bus.rf_beat), BW'(2'd0));
        check("midrst_done", BW'(bus.done), BW'(1'b0));
        check("midrst_ovf", BW'(bus.ovf), BW'(1'b0));
        check("midrst_zero", BW'(bus.zero), BW'(1'b1));
        tick();

        // Next command after reset runs normally.
        for (int i = 0; i < LANES; i++) d[i*DATA_W +: DATA_W] = DATA_W'(i);
        push_beat(d, 8'hFF, 5'd9, 1'b1);
        push_done(1'b0, 1'b0);
        send(OP_ADD, 1'b0, 32'd0, 32'd8, 5'd9);
        wait_done("done_cycle_after_rst", 1, 3);

        repeat (3) tick();
        check("beats_outstanding", BW'(exp_q.size()), BW'(0));
        check("dones_outstanding", BW'(done_q.size()), BW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vec_exe_unit.md
# vec_exe_unit

Parametrised vector execute unit for the vector-processor EXE stage. Takes one vector ALU command per handshake, walks the active vector length in beats of LANES elements, reads operand beats from the vector register file, and streams registered per-beat results with a destination register index and lane mask to write-back. Replaces the fixed 8-lane, counter-driven vector path. Adds backpressure, tail masking, scalar-broadcast mode and per-command overflow/zero flags.

## Interface
- DATA_W, 32, element width in bits
- LANES, 8, elements processed per beat
- VLEN_MAX, 32, maximum elements per command; must be a multiple of LANES
- ADDR_W, 5, vector register index width
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid && in_ready
- in_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 SRA
- in_scalar  in  1  1: operand B is in_rs2 broadcast to all lanes
- in_rs2  in  DATA_W  scalar operand B
- in_vlen  in  DATA_W  active element count
- in_rd_base  in  ADDR_W  first destination register
- rf_beat  out  log2(VLEN_MAX/LANES) (min 1)  beat index requested from the register file
- vs1_data, vs2_data  in  LANES*DATA_W  operand beats, combinational from the register file for rf_beat; lane i at [i*DATA_W +: DATA_W]
- wb_valid  out  1  result beat valid
- wb_ready  in  1  write-back accepts beat
- wb_data  out  LANES*DATA_W  result beat
- wb_mask  out  LANES  lane i active
- wb_addr  out  ADDR_W  destination register of this beat
- wb_last  out  1  final beat of the command
- done  out  1  one-cycle pulse at command completion
- ovf  out  1  overflow flag of the last completed command, held until the next done
- zero  out  1  1 when every active result element of the last completed command is 0, held until the next done

## Operation
- FSM states: IDLE, RUN.
- IDLE: in_ready = 1 only when wb_valid = 0. On accept, latch op, scalar, rs2, rd_base, and vlen_eff = min(in_vlen, VLEN_MAX). Compute beats = ceil(vlen_eff/LANES). If beats = 0, stay in IDLE and pulse done next cycle with zero = 1, ovf = 0. Otherwise go to RUN with beat = 0 and clear the accumulators.
- RUN: a beat issues when the output register is empty or wb_ready = 1. On issue, the lane results, mask, wb_addr = (rd_base + beat) mod 2^ADDR_W and wb_last = (beat == beats-1) load into the output register, and beat increments. After the last beat issues, return to IDLE.
- Mask: lane i is active iff beat*LANES + i < vlen_eff. Inactive lanes output 0 and do not affect ovf or zero.
- Arithmetic: ADD/SUB are DATA_W-bit two's complement; overflow is signed overflow. SLT gives 1/0. SLL/SRA shift by B[log2(DATA_W)-1:0]. Logic ops never overflow.
- The ovf and zero accumulators fold over issued beats. ovf/zero outputs update in the same cycle done pulses.
- done pulses in the cycle after the wb_last beat handshakes (wb_valid && wb_ready && wb_last).
- wb_data/mask/addr/last hold stable while wb_valid && !wb_ready.

## Timing
- Reset values: in_ready 0 during reset, 1 the first cycle after. wb_valid, wb_data, wb_mask, wb_addr, wb_last, done, ovf and rf_beat are 0; zero is 1; FSM is in IDLE.
- Accept at cycle 0 → rf_beat = 0 at cycle 1 → wb_valid with beat 0 at cycle 2. With wb_ready held high, one beat per cycle; beat k appears at cycle k+2.
- done arrives at cycle beats+2 with no stalls.
- New commands are not accepted until the output register drains, so there is no overlap between commands.
- rst mid-command: the next cycle is IDLE, in-flight beats are dropped, wb_valid = 0, done is not pulsed, and flags return to reset values.
- rd_base + beat wraps modulo 2^ADDR_W.

## Configuration
- VEXE_SAT_EN defined: ADD/SUB saturate to the signed max/min on overflow, and ovf still reports the saturation event.
- VEXE_SAT_EN undefined: ADD/SUB wrap.

## Test plan
- ADD, vlen=8, LANES=8, vs1 lanes = i, vs2 lanes = 10 → one beat: wb_data lanes 10..17, mask 0xFF, wb_last=1, done at cycle 3, ovf=0, zero=0.
- SUB scalar, vlen=11, rs2=1, vs1 all 1, rd_base=31 → two beats: addr 31 then 0 (wrap); masks 0xFF then 0x07; zero=1.
- ADD with 0x7FFFFFFF + 1 in lane 3 → ovf=1. Lane 3 = 0x80000000 without VEXE_SAT_EN, 0x7FFFFFFF with it.
- vlen=0 → no wb_valid, done one cycle after accept, zero=1. vlen=100 → clamped to 32, four beats.
- wb_ready low for 3 cycles on beat 1 of a 4-beat SRA → wb outputs hold stable and rf_beat does not advance past 2. in_valid stays blocked until drain.
- rst asserted while beat 2 is in flight → next cycle wb_valid=0, FSM IDLE, in_ready=1; the following command runs normally.
